// File: rtl/board_pkg.sv
// Shared types and constants for the board click decoder.
// Bevel rejection is compiled in with CLICK_MARGIN_EN.
package board_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        DIV_X = 3'd2,
        DIV_Y = 3'd3,
        HOLD  = 3'd4
    } click_state_e;

    localparam int MARGIN_DEF = 5;
    localparam int POS_W      = 12;

endpackage

// File: rtl/game_set_if.sv
// Board geometry bundle shared by the game logic and its consumers.
interface game_set_if;
    logic [10:0] board_xpos;
    logic [10:0] board_ypos;
    logic [10:0] board_size;
    logic [5:0]  button_size;
    logic [5:0]  button_num;

    modport in (
        input board_xpos, board_ypos, board_size,
        input button_size, button_num
    );

    modport out (
        output board_xpos, board_ypos, board_size,
        output button_size, button_num
    );
endinterface

// File: rtl/board_click_decoder_axis_div.sv
// Repeated-subtraction divider: start loads the dividend, one
// subtraction per step cycle until the remainder drops below divisor.
module axis_div #(
    parameter int W  = 12,
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          step_i,
    input  logic [W-1:0]  dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          done_o,
    output logic [W-1:0]  rem_o,
    output logic [W-1:0]  quo_o
);
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] div_ext;

    assign div_ext = W'(divisor_i);
    // A zero divisor would never terminate; treat it as finished.
    assign done_o  = (rem_q < div_ext) || (divisor_i == '0);
    assign rem_o   = rem_q;
    assign quo_o   = quo_q;

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        if (start_i) begin
            rem_d = dividend_i;
            quo_d = '0;
        end else if (step_i && !done_o) begin
            rem_d = rem_q - div_ext;
            quo_d = quo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end
endmodule

// File: rtl/board_click_decoder.sv
// Turns mouse button edges into board button column/row clicks.
// Define CLICK_MARGIN_EN to ignore clicks on a button's bevel.
module board_click_decoder
    import board_pkg::*;
#(
    parameter int MARGIN = MARGIN_DEF,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      mouse_xpos,
    input  logic [11:0]      mouse_ypos,
    input  logic             mouse_left,
    input  logic             mouse_right,
    game_set_if.in           gin,
    output logic             click_valid,
    output logic             click_right,
    output logic [IDX_W-1:0] click_col,
    output logic [IDX_W-1:0] click_row,
    input  logic             click_ack,
    output logic             busy
);
    click_state_e state_q, state_d;

    logic             left_q, right_q, armed_q;
    logic [POS_W-1:0] x_q, y_q;
    logic             type_q;
    logic [POS_W-1:0] col_q;
    logic             cright_q;
    logic [IDX_W-1:0] ccol_q, crow_q;

    logic             ledge, redge;
    logic [POS_W-1:0] bx, by, bsz, bnum;
    logic [POS_W-1:0] x_end, y_end;
    logic             accept, in_range, margin_ok;
    logic             div_start, div_step, div_done, load_out;
    logic [POS_W-1:0] div_in, div_rem, div_quo;

    // Edges are masked for one cycle after reset so a held button is quiet.
    assign ledge = armed_q && mouse_left && !left_q;
    assign redge = armed_q && mouse_right && !right_q;

    assign bx    = POS_W'(gin.board_xpos);
    assign by    = POS_W'(gin.board_ypos);
    assign bsz   = POS_W'(gin.board_size);
    assign bnum  = POS_W'(gin.button_num);
    assign x_end = bx + bsz;
    assign y_end = by + bsz;

    assign accept = (x_q >= bx) && (x_q < x_end) &&
                    (y_q >= by) && (y_q < y_end) &&
                    (gin.button_size != '0);

    assign in_range = (col_q < bnum) && (div_quo < bnum);
    assign div_in   = (state_q == LATCH) ? (x_q - bx) : (y_q - by);
    assign div_step = (state_q == DIV_X) || (state_q == DIV_Y);

`ifdef CLICK_MARGIN_EN
    logic [POS_W-1:0] remx_q;

    function automatic logic in_face(input logic [POS_W-1:0] r,
                                     input logic [5:0] bs);
        return (int'(r) >= MARGIN) &&
               (int'(r) + MARGIN + 1 <= int'(bs));
    endfunction

    assign margin_ok = in_face(remx_q, gin.button_size) &&
                       in_face(div_rem, gin.button_size);

    always_ff @(posedge clk) begin
        if (rst)
            remx_q <= '0;
        else if (state_q == DIV_X && div_done)
            remx_q <= div_rem;
    end
`else
    assign margin_ok = 1'b1;
`endif

    axis_div #(.W(POS_W), .DW(6)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (div_start),
        .step_i    (div_step),
        .dividend_i(div_in),
        .divisor_i (gin.button_size),
        .done_o    (div_done),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        load_out  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ledge || redge)
                    state_d = LATCH;
            end
            LATCH: begin
                if (accept) begin
                    state_d   = DIV_X;
                    div_start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV_X: begin
                if (div_done) begin
                    state_d   = DIV_Y;
                    div_start = 1'b1;
                end
            end
            DIV_Y: begin
                if (div_done) begin
                    if (in_range && margin_ok) begin
                        state_d  = HOLD;
                        load_out = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (click_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            armed_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            type_q   <= 1'b0;
            col_q    <= '0;
            cright_q <= 1'b0;
            ccol_q   <= '0;
            crow_q   <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= mouse_left;
            right_q <= mouse_right;
            armed_q <= 1'b1;
            if (state_q == IDLE && (ledge || redge)) begin
                x_q    <= mouse_xpos;
                y_q    <= mouse_ypos;
                type_q <= !ledge;
            end
            if (state_q == DIV_X && div_done)
                col_q <= div_quo;
            if (load_out) begin
                ccol_q   <= col_q[IDX_W-1:0];
                crow_q   <= div_quo[IDX_W-1:0];
                cright_q <= type_q;
            end
        end
    end

    assign click_valid = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign click_col   = ccol_q;
    assign click_row   = crow_q;
    assign click_right = cright_q;
endmodule

// File: tb/tb_board_click_decoder.sv
// Directed checks of the board click decoder.
`timescale 1ns/1ps
module tb_board_click_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        mouse_left, mouse_right;
    logic        click_valid, click_right, click_ack, busy;
    logic [5:0]  click_col, click_row;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int seen;

    game_set_if gset();

    board_click_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .mouse_right(mouse_right),
        .gin        (gset),
        .click_valid(click_valid),
        .click_right(click_right),
        .click_col  (click_col),
        .click_row  (click_row),
        .click_ack  (click_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until click_valid; returns the tick count, 0 on timeout.
    task automatic wait_valid(input int max, output int n);
        n = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (click_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic watch(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (click_valid) hits++;
        end
    endtask

    task automatic ack_click();
        click_ack = 1'b1;
        tick();
        click_ack = 1'b0;
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_valid"}, click_valid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_col"},   click_col, 0);
        check({tag, "_row"},   click_row, 0);
        check({tag, "_right"}, click_right, 0);
    endtask

    task automatic geom(input int bsz, input int bs, input int bn);
        gset.board_xpos  = 11'd100;
        gset.board_ypos  = 11'd100;
        gset.board_size  = 11'(bsz);
        gset.button_size = 6'(bs);
        gset.button_num  = 6'(bn);
    endtask

    initial begin
        int exp_lat;
        rst = 1'b1;
        mouse_xpos = '0;
        mouse_ypos = '0;
        mouse_left = 1'b0;
        mouse_right = 1'b0;
        click_ack = 1'b0;
        geom(200, 20, 10);
        tick();
        tick();
        outputs_zero("reset");
        rst = 1'b0;
        tick();
        tick();

        // Normal left click: offset (45,65) -> col 2, row 3
        mouse_xpos = 12'd145;
        mouse_ypos = 12'd165;
        mouse_left = 1'b1;
        wait_valid(200, lat);
        check("norm_lat", lat, 9);
        check("norm_col", click_col, 2);
        check("norm_row", click_row, 3);
        check("norm_right", click_right, 0);
        mouse_left = 1'b0;
        tick(); tick(); tick();
        check("norm_hold_valid", click_valid, 1);
        check("norm_hold_col", click_col, 2);
        ack_click();
        check("norm_ack_valid", click_valid, 0);
        check("norm_ack_busy", busy, 0);

        // Right clicks just outside either edge of the board
        mouse_xpos = 12'd99;
        mouse_ypos = 12'd150;
        mouse_right = 1'b1;
        tick();
        check("out_lo_busy1", busy, 1);
        tick();
        check("out_lo_busy2", busy, 0);
        watch(20, seen);
        check("out_lo_novalid", seen, 0);
        mouse_right = 1'b0;
        tick();
        mouse_xpos = 12'd300;
        mouse_right = 1'b1;
        tick();
        check("out_hi_busy1", busy, 1);
        tick();
        check("out_hi_busy2", busy, 0);
        watch(20, seen);
        check("out_hi_novalid", seen, 0);
        mouse_right = 1'b0;
        tick();

        // Both buttons at once: left wins; later edge while busy dropped
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd100;
        mouse_left = 1'b1;
        mouse_right = 1'b1;
        tick();
        mouse_left = 1'b0;
        mouse_right = 1'b0;
        tick();
        mouse_xpos = 12'd280;
        mouse_ypos = 12'd280;
        mouse_right = 1'b1;
        wait_valid(50, lat);
        check("both_lat", lat, 2);
        check("both_col", click_col, 0);
        check("both_row", click_row, 0);
        check("both_right", click_right, 0);
        ack_click();
        watch(30, seen);
        check("both_dropped", seen, 0);
        mouse_right = 1'b0;
        tick();

        // Bevel click at offset (22,30)
`ifdef CLICK_MARGIN_EN
        exp_lat = 0;
`else
        exp_lat = 6;
`endif
        mouse_xpos = 12'd122;
        mouse_ypos = 12'd130;
        mouse_left = 1'b1;
        wait_valid(50, lat);
        check("margin_lat", lat, 32'(exp_lat));
        if (lat != 0) begin
            check("margin_col", click_col, 1);
            check("margin_row", click_row, 1);
            ack_click();
        end
        mouse_left = 1'b0;
        tick(); tick();
        check("margin_idle", busy, 0);

        // Reset during DIV_X with the button held through release
        mouse_xpos = 12'd145;
        mouse_ypos = 12'd165;
        mouse_left = 1'b1;
        tick();
        tick();
        check("rstdiv_busy", busy, 1);
        rst = 1'b1;
        tick();
        outputs_zero("rstdiv");
        rst = 1'b0;
        watch(30, seen);
        check("rstdiv_noclick", seen, 0);
        check("rstdiv_idle", busy, 0);
        mouse_left = 1'b0;
        tick();

        // Reset while holding a click
        mouse_left = 1'b1;
        wait_valid(50, lat);
        check("rsthold_lat", lat, 9);
        rst = 1'b1;
        tick();
        outputs_zero("rsthold");
        rst = 1'b0;
        watch(30, seen);
        check("rsthold_noclick", seen, 0);
        mouse_left = 1'b0;
        tick();

        // Offset 205 of a 210 board with 10 buttons -> col 10, rejected
        geom(210, 20, 10);
        mouse_xpos = 12'd305;
        mouse_ypos = 12'd100;
        mouse_left = 1'b1;
        watch(40, seen);
        check("corner_noclick", seen, 0);
        check("corner_idle", busy, 0);
        mouse_left = 1'b0;
        tick();

        // Zero button size rejected in LATCH
        geom(200, 0, 10);
        mouse_xpos = 12'd150;
        mouse_ypos = 12'd150;
        mouse_left = 1'b1;
        tick();
        check("bs0_busy1", busy, 1);
        tick();
        check("bs0_busy2", busy, 0);
        watch(10, seen);
        check("bs0_noclick", seen, 0);
        mouse_left = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
